// File: rtl/fft_pkg.sv
`timescale 1ns/1ps
// fft_pkg: shared types and constants for the 8-point FFT front end.
//   FFT_N        frame length (8)
//   FFT_DATA_W   sample width (9, two's complement)
//   sample_t     one signed sample
//   frame_t      8 samples, packed so element i sits at bits [i*9 +: 9]
//   FFT_HOP_*    number of new samples between frame captures
package fft_pkg;

    localparam int FFT_N      = 8;
    localparam int FFT_DATA_W = 9;

    localparam logic [3:0] FFT_HOP_FULL = 4'd8;
    localparam logic [3:0] FFT_HOP_HALF = 4'd4;

    typedef logic signed [FFT_DATA_W-1:0] sample_t;
    typedef sample_t [FFT_N-1:0]          frame_t;

endpackage

// File: rtl/sample_history.sv
`timescale 1ns/1ps
// sample_history: 8-entry sample shift register with parallel tap-out.
// Entry 0 is the oldest sample, entry 7 the newest.
// Ports:
//   clk_in    system clock
//   clr       synchronous clear of all entries (active high)
//   shift_en  shift in din: hist[i] <= hist[i+1], hist[7] <= din
//   din       incoming sample
//   taps      current contents, element i = hist[i]
module sample_history
    import fft_pkg::*;
(
    input  logic    clk_in,
    input  logic    clr,
    input  logic    shift_en,
    input  sample_t din,
    output frame_t  taps
);

    frame_t hist_r;

    // History shift register: clear wins over shift.
    always_ff @(posedge clk_in) begin
        if (clr) begin
            hist_r <= {(FFT_N*FFT_DATA_W){1'b0}};
        end else if (shift_en) begin
            hist_r <= {din, hist_r[FFT_N-1:1]};
        end else begin
            hist_r <= hist_r;
        end
    end

    assign taps = hist_r;

endmodule

// File: rtl/fft_input_framer.sv
`timescale 1ns/1ps
// fft_input_framer: collects a valid/ready sample stream into 8-sample
// frames for the FFT core. A frame is captured on the accept that brings the
// count of new samples up to the hop; the frame register holds it until the
// FFT takes it.
//
// Compile-time option FFT_FRAMER_OVERLAP_EN: after the first frame the hop
// drops to 4, giving 50%-overlapped frames. Undefined: hop fixed at 8.
//
// Ports:
//   clk_in    system clock
//   rst       synchronous active-high reset
//   s_valid   / s_ready / s_data   sample input handshake
//   f_valid   / f_ready / f_data   frame output handshake (x0 oldest, bits [i*9 +: 9])
//   f_count   frames captured since reset, wraps at 256
//   overrun   sticky: a sample was offered while s_ready was low
module fft_input_framer
    import fft_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W,
    parameter int N      = FFT_N
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DATA_W-1:0]   s_data,
    output logic                f_valid,
    input  logic                f_ready,
    output logic [N*DATA_W-1:0] f_data,
    output logic [7:0]          f_count,
    output logic                overrun
);

    sample_t     s_sample_s;
    frame_t      taps_s;
    frame_t      post_shift_s;
    frame_t      f_data_r;
    logic [3:0]  cnt_r;
    logic [3:0]  hop_s;
    logic [3:0]  hop_m1_s;
    logic        out_free_s;
    logic        s_ready_s;
    logic        accept_s;
    logic        capture_s;
    logic        f_valid_r;
    logic [7:0]  f_count_r;
    logic        overrun_r;

    assign s_sample_s = sample_t'(s_data);

    sample_history u_hist (
        .clk_in   (clk_in),
        .clr      (rst),
        .shift_en (accept_s),
        .din      (s_sample_s),
        .taps     (taps_s)
    );

`ifdef FFT_FRAMER_OVERLAP_EN
    logic primed_r;

    // Primed marks that the first full frame has been taken; hop halves afterwards.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            primed_r <= 1'b0;
        end else if (capture_s) begin
            primed_r <= 1'b1;
        end else begin
            primed_r <= primed_r;
        end
    end
`endif

    // Hop selection: number of new samples needed before the next capture.
    always_comb begin
        hop_s = FFT_HOP_FULL;
`ifdef FFT_FRAMER_OVERLAP_EN
        if (primed_r) begin
            hop_s = FFT_HOP_HALF;
        end else begin
            hop_s = FFT_HOP_FULL;
        end
`endif
    end

    // Handshake decode. Only the frame-completing sample (cnt == hop-1) can be
    // stalled, and only while an unconsumed frame would be overwritten.
    // s_ready never looks at s_valid, so there is no valid->ready loop.
    always_comb begin
        out_free_s   = !f_valid_r || f_ready;
        hop_m1_s     = hop_s - 4'd1;
        s_ready_s    = !rst && ((cnt_r != hop_m1_s) || out_free_s);
        accept_s     = s_valid && s_ready_s;
        capture_s    = accept_s && (cnt_r == hop_m1_s);
        // Frame as it will look after this accept: new sample lands in x7.
        post_shift_s = {s_sample_s, taps_s[FFT_N-1:1]};
    end

    // Sample counter, frame register, frame counter and overrun flag.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt_r     <= 4'd0;
            f_valid_r <= 1'b0;
            f_data_r  <= {(FFT_N*FFT_DATA_W){1'b0}};
            f_count_r <= 8'd0;
            overrun_r <= 1'b0;
        end else begin
            if (capture_s) begin
                cnt_r <= 4'd0;
            end else if (accept_s) begin
                cnt_r <= cnt_r + 4'd1;
            end else begin
                cnt_r <= cnt_r;
            end

            // A capture can coincide with the FFT taking the old frame;
            // f_valid then simply stays high with the new contents.
            if (capture_s) begin
                f_valid_r <= 1'b1;
                f_data_r  <= post_shift_s;
                f_count_r <= f_count_r + 8'd1;
            end else if (f_ready) begin
                f_valid_r <= 1'b0;
                f_data_r  <= f_data_r;
                f_count_r <= f_count_r;
            end else begin
                f_valid_r <= f_valid_r;
                f_data_r  <= f_data_r;
                f_count_r <= f_count_r;
            end

            if (s_valid && !s_ready_s) begin
                overrun_r <= 1'b1;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    assign s_ready = s_ready_s;
    assign f_valid = f_valid_r;
    assign f_data  = f_data_r;
    assign f_count = f_count_r;
    assign overrun = overrun_r;

endmodule

// File: doc/fft_input_framer.md
# fft_input_framer

Upstream feeder for the 8-point radix-2 DIT FFT core. Accepts a stream of signed 9-bit audio samples over a valid/ready handshake, keeps an 8-deep sample history and, once enough new samples have arrived, captures a complete 8-sample frame into a holding register. The FFT consumes the frame in parallel, in natural order (x0 = oldest). An optional compile-time mode emits 50%-overlapped frames.

## Interface
- `DATA_W`, 9: sample width, two's complement; matches the FFT datapath.
- `N`, 8: frame length; fixed at 8, and the hop logic assumes it.
- `clk_in`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `s_valid`  in  1  input sample valid.
- `s_ready`  out  1  framer can accept a sample this cycle.
- `s_data`  in  DATA_W  input sample.
- `f_valid`  out  1  frame register holds an unconsumed frame.
- `f_ready`  in  1  FFT accepts the frame this cycle.
- `f_data`  out  N*DATA_W  frame; x[i] at bits [i*DATA_W +: DATA_W], x0 oldest, x7 newest.
- `f_count`  out  8  frames emitted since reset; wraps 255→0.
- `overrun`  out  1  sticky flag: `s_valid` seen while `s_ready` = 0.

## Operation
- Accept = `s_valid && s_ready`. On accept, the history shifts: `hist[i] <= hist[i+1]`, `hist[7] <= s_data`.
- `cnt` (4 bits) counts accepted samples since the last capture.
- `primed` is set by the first capture.
- The hop is 8 by default. It is 4 when `FFT_FRAMER_OVERLAP_EN` is defined and `primed` = 1.
- Capture occurs on an accept that makes `cnt` equal the hop.
  - `f_data` loads the post-shift history (the new sample becomes x7).
  - `cnt` returns to 0.
  - `f_valid` is set.
  - `f_count` increments.
- `out_free` = `!f_valid || f_ready`.
- `s_ready` = `!rst && ((cnt != hop-1) || out_free)`. Only the frame-completing sample can stall; the other samples always flow.
- Frame handshake: when `f_valid && f_ready`, `f_valid` clears unless a capture occurs in the same cycle, in which case it stays 1 and `f_data` takes the new frame.
- `f_data` is stable while `f_valid && !f_ready`.
- `overrun` is set by `s_valid && !s_ready && !rst` and is cleared only by `rst`.
- No arithmetic is performed on samples; they pass through bit-exact.

## Timing
- Reset values: `hist` = 0, `cnt` = 0, `primed` = 0, `f_valid` = 0, `f_data` = 0, `f_count` = 0, `overrun` = 0.
- `s_ready` is 0 while `rst` is high and 1 in the first cycle after reset.
- Latency: the completing sample is accepted at edge k; `f_valid` = 1 and `f_data` is valid after edge k, with 1-cycle latency.
- Throughput: one sample per cycle, sustained, whenever the FFT takes each frame within hop-1 cycles.
- Completing sample arrives while the frame is still pending: `s_ready` = 0 and the sample is held off. The accept happens in the cycle that `f_ready` is asserted, and that same edge consumes the old frame and loads the new one.
- Reset mid-frame: partial history is discarded and `primed` clears, so the next frame needs 8 fresh samples.
- `s_ready` depends combinationally on `f_ready`. There is no combinational path from `s_valid` to `s_ready`.

## Configuration
- `FFT_FRAMER_OVERLAP_EN` defined:
  - The first frame after reset needs 8 samples.
  - Each later frame needs 4 new samples.
  - Consecutive frames share 4 samples: frame n x4..x7 equals frame n+1 x0..x3.
- `FFT_FRAMER_OVERLAP_EN` undefined:
  - The hop is always 8 and frames are disjoint.
  - The `primed` register is not built.

## Structure
- Shared package `fft_pkg`:
  - `FFT_N` = 8.
  - `FFT_DATA_W` = 9.
  - `sample_t` = signed [8:0].
  - `frame_t` = array of 8 `sample_t`.
  - Hop constants `FFT_HOP_FULL` = 8 and `FFT_HOP_HALF` = 4.
- One sub-module, `sample_history`: an 8-entry shift register with a shift enable, a synchronous clear and a parallel tap-out. Hop control, the output register and the handshakes stay in `fft_input_framer`.

## Test plan
- Reset, then samples 1..8 with `f_ready` = 1: a single `f_valid` pulse; `f_data` x0..x7 = 1..8; `f_count` = 1.
- Samples 1..16 back-to-back with `f_ready` = 0 until the 16th is offered:
  - `s_ready` = 0 for sample 16 only.
  - The first frame is 1..8.
  - The second frame is 9..16 after `f_ready` rises.
  - `overrun` = 1.
- Samples -256, 255, 0, -1, ... (the extreme values): the frame reproduces them bit-exact, with no sign loss.
- With `FFT_FRAMER_OVERLAP_EN`, samples 1..16 and `f_ready` = 1: frames 1..8, 5..12 and 9..16; `f_count` = 3.
- `rst` pulsed after 5 samples, then samples 10..17: the first frame is 10..17, with no stale data.
- 2048 frames streamed: `f_count` wraps 255→0 and no sample is lost or duplicated (scoreboard check).
